// File: rtl/led_anim_pkg.sv
// Shared types and helpers for the LED animation step generator.
package led_anim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  localparam int                STEP_W    = 5;
  localparam logic [STEP_W-1:0] STEP_LAST = 5'd31;

  // Frame period in clock cycles for a given speed setting.
  function automatic int speed_div(int base, logic [1:0] spd);
    return base >> spd;
  endfunction

endpackage

// File: rtl/led_anim_sequencer_if.sv
// Control/status bundle between a playback controller and the sequencer.
// The bounce input exists only when LED_ANIM_PINGPONG_EN is defined.
interface led_anim_sequencer_if;
  import led_anim_pkg::*;

  logic              start;
  logic              stop;
  logic              pause;
  logic              oneshot;
  logic [1:0]        speed;
`ifdef LED_ANIM_PINGPONG_EN
  logic              bounce;
`endif
  logic [STEP_W-1:0] step;
  logic              step_tick;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, pause, oneshot, speed,
`ifdef LED_ANIM_PINGPONG_EN
    output bounce,
`endif
    input  step, step_tick, busy, done
  );

  modport slave (
    input  start, stop, pause, oneshot, speed,
`ifdef LED_ANIM_PINGPONG_EN
    input  bounce,
`endif
    output step, step_tick, busy, done
  );

endinterface

// File: rtl/led_anim_prescaler.sv
// Frame-rate prescaler: counts while enabled, flags the last cycle of a period.
module led_anim_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             term
);

  logic [DIV_W-1:0] r_cnt;

  // ">=" so a shorter period chosen mid-count terminates right away.
  assign term = en && (r_cnt >= div - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= term ? '0 : r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/led_anim_sequencer.sv
// Frame-index sequencer for the 7-segment animation path (start/stop/pause,
// loop or one-shot). Define LED_ANIM_PINGPONG_EN for up/down bounce playback.
module led_anim_sequencer
  import led_anim_pkg::*;
#(
  parameter int BASE_DIV = 12_500_000,
  parameter int DIV_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  led_anim_sequencer_if.slave  bus
);

  state_e            r_state, w_nxt_state;
  logic [STEP_W-1:0] r_step, w_nxt_step, w_adv_step;
  logic              r_tick, w_nxt_tick;
  logic              r_busy, r_done;
  logic              r_os, w_nxt_os;
  logic              w_adv_done;
  logic [DIV_W-1:0]  w_div;
  logic              w_clr, w_en, w_term;
`ifdef LED_ANIM_PINGPONG_EN
  logic              r_dir, w_nxt_dir, w_adv_dir;  // 0 = counting up
  logic              r_bounce, w_nxt_bounce;
`endif

  assign w_div = DIV_W'(speed_div(BASE_DIV, bus.speed));
  assign w_clr = bus.stop | bus.start;
  // Prescaler gated off when pausing so a coincident terminal is dropped.
  assign w_en  = (r_state == RUN) && !bus.stop && !bus.start && !bus.pause;

  led_anim_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .div  (w_div),
    .term (w_term)
  );

  // Where the step goes on a terminal count, and whether playback ends there.
  always_comb begin
    w_adv_done = 1'b0;
    w_adv_step = r_step + STEP_W'(1);
`ifdef LED_ANIM_PINGPONG_EN
    w_adv_dir  = r_dir;
    if (r_bounce) begin
      if (r_dir) begin
        if (r_step == '0) begin
          w_adv_done = r_os;
          w_adv_dir  = 1'b0;
          w_adv_step = STEP_W'(1);
        end else begin
          w_adv_step = r_step - STEP_W'(1);
        end
      end else if (r_step == STEP_LAST) begin
        w_adv_dir  = 1'b1;
        w_adv_step = STEP_LAST - STEP_W'(1);
      end
    end else if (r_os && r_step == STEP_LAST) begin
      w_adv_done = 1'b1;
    end
`else
    if (r_os && r_step == STEP_LAST)
      w_adv_done = 1'b1;
`endif
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_step   = r_step;
    w_nxt_tick   = 1'b0;
    w_nxt_os     = r_os;
`ifdef LED_ANIM_PINGPONG_EN
    w_nxt_dir    = r_dir;
    w_nxt_bounce = r_bounce;
`endif
    if (bus.stop) begin
      w_nxt_state = IDLE;
      w_nxt_step  = '0;
`ifdef LED_ANIM_PINGPONG_EN
      w_nxt_dir   = 1'b0;
`endif
    end else if (bus.start) begin
      w_nxt_state  = RUN;
      w_nxt_step   = '0;
      w_nxt_os     = bus.oneshot;
`ifdef LED_ANIM_PINGPONG_EN
      w_nxt_dir    = 1'b0;
      w_nxt_bounce = bus.bounce;
`endif
    end else begin
      case (r_state)
        IDLE:  w_nxt_step = '0;
        RUN: begin
          if (bus.pause) begin
            w_nxt_state = PAUSE;
          end else if (w_term) begin
            if (w_adv_done) begin
              w_nxt_state = DONE;
            end else begin
              w_nxt_step = w_adv_step;
              w_nxt_tick = 1'b1;
`ifdef LED_ANIM_PINGPONG_EN
              w_nxt_dir  = w_adv_dir;
`endif
            end
          end
        end
        PAUSE: if (!bus.pause) w_nxt_state = RUN;
        DONE:  ;
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= '0;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_os     <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
      r_dir    <= 1'b0;
      r_bounce <= 1'b0;
`endif
    end else begin
      r_step   <= w_nxt_step;
      r_tick   <= w_nxt_tick;
      r_busy   <= (w_nxt_state == RUN) || (w_nxt_state == PAUSE);
      r_done   <= (w_nxt_state == DONE);
      r_os     <= w_nxt_os;
`ifdef LED_ANIM_PINGPONG_EN
      r_dir    <= w_nxt_dir;
      r_bounce <= w_nxt_bounce;
`endif
    end
  end

  assign bus.step      = r_step;
  assign bus.step_tick = r_tick;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's
// outputs; a negedge monitor compares them against the sequencer.
module tb_led_anim_sequencer;

  localparam int BASE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_anim_sequencer_if bus();

  led_anim_sequencer #(.BASE_DIV(BASE), .DIV_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] vec;  // {step, step_tick, busy, done}
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input levels held between pulses
  bit lv_pause = 0, lv_os = 0, lv_bnc = 0;
  int lv_speed = 0;

  // Reference model: playback is a position along a frame sequence.
  // 0 idle, 1 run, 2 pause, 3 done
  int m_st = 0, m_cnt = 0, m_pos = 0;
  bit m_tick = 0, m_os = 0, m_bnc = 0;

  function automatic int frame_of(int pos, bit bnc);
    int p;
    if (!bnc) return pos % 32;
    p = pos % 62;
    return (p <= 31) ? p : 62 - p;
  endfunction

  task automatic model(input bit r, input bit s, input bit t);
    int per;
    m_tick = 0;
    if (r) begin
      m_st = 0; m_cnt = 0; m_pos = 0; m_os = 0; m_bnc = 0;
    end else if (t) begin
      m_st = 0; m_cnt = 0; m_pos = 0;
    end else if (s) begin
      m_st = 1; m_cnt = 0; m_pos = 0; m_os = lv_os; m_bnc = lv_bnc;
    end else if (m_st == 1) begin
      if (lv_pause) m_st = 2;
      else begin
        per = BASE >> lv_speed;
        if (m_cnt >= per - 1) begin
          m_cnt = 0;
          if (m_os && m_pos == (m_bnc ? 62 : 31)) m_st = 3;
          else begin m_pos++; m_tick = 1; end
        end else m_cnt++;
      end
    end else if (m_st == 2) begin
      if (!lv_pause) m_st = 1;
    end
  endtask

  task automatic step_cyc(input bit r, input bit s, input bit t);
    exp_t e;
    @(posedge clk); #1;
    rst         = r;
    bus.start   = s;
    bus.stop    = t;
    bus.pause   = lv_pause;
    bus.oneshot = lv_os;
    bus.speed   = 2'(lv_speed);
`ifdef LED_ANIM_PINGPONG_EN
    bus.bounce  = lv_bnc;
`endif
    model(r, s, t);
    e.cyc = cyc + 1;
    e.vec = {5'(frame_of(m_pos, m_bnc)), m_tick, (m_st == 1 || m_st == 2), (m_st == 3)};
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step_cyc(0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {bus.step, bus.step_tick, bus.busy, bus.done};
      checks++;
      if (e.cyc != cyc || act !== e.vec) begin
        errors++;
        $display("FAIL outputs cyc=%0d got step=%0d tick=%b busy=%b done=%b want step=%0d tick=%b busy=%b done=%b",
                 cyc, act[7:3], act[2], act[1], act[0], e.vec[7:3], e.vec[2], e.vec[1], e.vec[0]);
      end
    end
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.oneshot = 0; bus.speed = 0;
`ifdef LED_ANIM_PINGPONG_EN
    bus.bounce = 0;
`endif
    // reset
    repeat (3) step_cyc(1, 0, 0);
    idle(4);
    // loop at speed 0, past the 31 -> 0 wrap
    step_cyc(0, 1, 0);
    idle(300);
    // one-shot at speed 2 into DONE, then quiet
    lv_os = 1; lv_speed = 2;
    step_cyc(0, 1, 0);
    idle(120);
    // pause mid-frame at step 3
    lv_os = 0; lv_speed = 0;
    step_cyc(0, 1, 0);
    idle(29);
    lv_pause = 1; idle(20);
    lv_pause = 0; idle(15);
    // start+stop together around step 12, then restart from DONE
    step_cyc(0, 1, 0);
    idle(97);
    step_cyc(0, 1, 1);
    idle(5);
    lv_os = 1; lv_speed = 3;
    step_cyc(0, 1, 0);
    idle(40);
    lv_os = 0;
    step_cyc(0, 1, 0);
    idle(10);
    // speed raised mid-count
    lv_speed = 0;
    step_cyc(0, 1, 0);
    idle(7);
    lv_speed = 3; idle(10);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, s, t;
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 29) == 0) lv_pause = ~lv_pause;
      if ($urandom_range(0, 49) == 0) lv_speed = $urandom_range(0, 3);
      lv_os = 1'($urandom_range(0, 1));
`ifdef LED_ANIM_PINGPONG_EN
      lv_bnc = 1'($urandom_range(0, 1));
`endif
      step_cyc(r, s, t);
    end
    lv_pause = 0;
    idle(3);
    @(posedge clk); @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
